// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage. Issues one request at a time to the
//            instruction memory, presents the returned word to decode, and
//            follows redirects from execute. A squash flag discards the
//            response of a request that was overtaken by a redirect.
// Ports    : clk, reset (sync, active-low)
//            imem_req_valid/imem_req_ready/imem_addr   - request channel
//            imem_rsp_valid/imem_rdata                 - response channel
//            redirect_valid/redirect_pc                - control-flow change
//            inst_valid/inst/inst_pc/inst_ack          - decode interface
//            fetch_count                               - delivered count
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ack,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        squash_q, squash_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    // Gating with reset keeps the request low during the reset cycle itself,
    // even before the state register has been initialised.
    assign imem_req_valid = (state_q == S_REQ) && !redirect_valid && reset;
    assign imem_addr      = pc_q;
    assign inst_valid     = (state_q == S_HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_count    = fetch_count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            squash_q      <= 1'b0;
            inst_q        <= 32'h0;
            inst_pc_q     <= 32'h0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            squash_q      <= squash_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        squash_d      = squash_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            S_REQ: begin
                // Responses arriving here are stray and are ignored.
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (imem_req_ready) begin
                    state_d  = S_WAIT;
                    squash_d = 1'b0;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_rsp_valid) begin
                        // Response lands together with the redirect: drop it
                        // and restart at the new PC.
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        // Request still in flight: its data must be dropped
                        // when it eventually returns.
                        squash_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + 32'd4;
                        state_d   = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    // A concurrent ack is not counted: the instruction is dead.
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (inst_ack) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking testbench for fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ack;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ack       (inst_ack),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ack       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_fetch_count: got %h expected 0", fetch_count); end
        checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst: got inst=%h pc=%h expected 0/0", inst, inst_pc); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        reset = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_release_req: got %b expected 1", imem_req_valid); end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL basic_req0: got v=%b a=%h expected 1/0", imem_req_valid, imem_addr); end
        tick();
        imem_req_ready = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL basic_wait: got req=%b iv=%b expected 0/0", imem_req_valid, inst_valid); end
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h1234_5678 || inst_pc !== 32'h0) begin errors++; $display("FAIL basic_inst: got v=%b i=%h pc=%h expected 1/12345678/0", inst_valid, inst, inst_pc); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL basic_count_pre: got %h expected 0", fetch_count); end
        inst_ack = 1'b1;
        tick();
        inst_ack = 1'b0;
        #1;
        checks++; if (fetch_count !== 32'h1) begin errors++; $display("FAIL basic_count: got %h expected 1", fetch_count); end
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL basic_next_req: got iv=%b v=%b a=%h expected 0/1/4", inst_valid, imem_req_valid, imem_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin errors++; $display("FAIL stall_%0d: got v=%b a=%h iv=%b expected 1/0/0", i, imem_req_valid, imem_addr, inst_valid); end
            tick();
        end
    endtask

    task automatic test_hold_stable();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hCAFE_F00D;
        tick();
        imem_rdata     = 32'h1111_1111;
        // A stray response while holding must not disturb the held word.
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (inst_valid !== 1'b1 || inst !== 32'hCAFE_F00D || inst_pc !== 32'h0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL hold_%0d: got v=%b i=%h pc=%h req=%b expected 1/cafef00d/0/0", i, inst_valid, inst, inst_pc, imem_req_valid); end
        end
        imem_rsp_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exp_addr = 32'(k) * 32'd4;
            imem_req_ready = 1'b1;
            #1;
            checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL b2b_addr_%0d: got %h expected %h", k, imem_addr, exp_addr); end
            tick();
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b1;
            imem_rdata     = 32'hA000_0000 + 32'(k);
            tick();
            imem_rsp_valid = 1'b0;
            inst_ack       = 1'b1;
            #1;
            checks++; if (inst !== 32'hA000_0000 + 32'(k) || inst_pc !== exp_addr) begin errors++; $display("FAIL b2b_inst_%0d: got i=%h pc=%h expected %h/%h", k, inst, inst_pc, 32'hA000_0000 + 32'(k), exp_addr); end
            tick();
            inst_ack = 1'b0;
        end
        #1;
        checks++; if (fetch_count !== 32'd3 || imem_addr !== 32'hC) begin errors++; $display("FAIL b2b_end: got cnt=%h a=%h expected 3/c", fetch_count, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_req_low: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_dropped: got inst_valid=%b expected 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100 || fetch_count !== 32'h0) begin errors++; $display("FAIL rdw_next: got v=%b a=%h cnt=%h expected 1/100/0", imem_req_valid, imem_addr, fetch_count); end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h0BAD_CAFE;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h0BAD_CAFE || inst_pc !== 32'h100) begin errors++; $display("FAIL rdw_deliver: got v=%b i=%h pc=%h expected 1/0badcafe/100", inst_valid, inst, inst_pc); end
    endtask

    task automatic test_double_redirect();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_pc    = 32'h180;
        tick();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h5555_5555;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h180) begin errors++; $display("FAIL dbl_redirect: got iv=%b v=%b a=%h expected 0/1/180", inst_valid, imem_req_valid, imem_addr); end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h7777_0000;
        tick();
        imem_rsp_valid = 1'b0;
        inst_ack       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        inst_ack       = 1'b0;
        redirect_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0 || fetch_count !== 32'h0) begin errors++; $display("FAIL rdh_drop: got iv=%b cnt=%h expected 0/0", inst_valid, fetch_count); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rdh_next: got v=%b a=%h expected 1/200", imem_req_valid, imem_addr); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hA5A5_A5A5;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (inst_pc !== 32'hFFFF_FFFC || inst !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wrap_inst: got i=%h pc=%h expected a5a5a5a5/fffffffc", inst, inst_pc); end
        inst_ack = 1'b1;
        tick();
        inst_ack = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0 || fetch_count !== 32'h1) begin errors++; $display("FAIL wrap_next: got a=%h cnt=%h expected 0/1", imem_addr, fetch_count); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rstw_req_low: got %b expected 0", imem_req_valid); end
        tick();
        reset          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hBADD_BADD;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rstw_stray: got iv=%b v=%b a=%h expected 0/1/0", inst_valid, imem_req_valid, imem_addr); end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rstw_wait: got iv=%b expected 0", inst_valid); end
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h0000_1234;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_1234 || inst_pc !== 32'h0) begin errors++; $display("FAIL rstw_deliver: got v=%b i=%h pc=%h expected 1/1234/0", inst_valid, inst, inst_pc); end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_basic_fetch();
        test_stall();
        test_hold_stable();
        test_back_to_back();
        test_redirect_wait();
        test_double_redirect();
        test_redirect_hold();
        test_pc_wrap();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Parameters
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.

Interface
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset: reset==0 at a posedge resets the block.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-006 imem_addr  output  32  fetch address, equals the current PC.
REQ-007 imem_rsp_valid  input  1  read data valid, one pulse per accepted request.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 redirect_valid  input  1  jump/branch/interrupt redirect from execute.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 inst_valid  output  1  instruction available to decode.
REQ-012 inst  output  32  instruction word.
REQ-013 inst_pc  output  32  PC of inst.
REQ-014 inst_ack  input  1  decode consumes inst this cycle.
REQ-015 fetch_count  output  32  count of instructions delivered (inst_valid & inst_ack & !redirect_valid).

Function
REQ-016 SHALL implement FSM states S_REQ, S_WAIT and S_HOLD, plus a 1-bit squash flag.
REQ-017 S_REQ: imem_req_valid = !redirect_valid; imem_addr = pc; a handshake (valid & ready) SHALL move to S_WAIT with squash=0.
REQ-018 imem_req_valid SHALL be forced low in any cycle with redirect_valid=1, so a request is never accepted in a redirect cycle.
REQ-019 imem_addr SHALL stay stable while imem_req_valid=1 and imem_req_ready=0.
REQ-020 S_WAIT, on imem_rsp_valid with squash=0 and no redirect: latch inst<=imem_rdata, inst_pc<=pc, pc<=pc+4, then go to S_HOLD.
REQ-021 Latency: instruction on inst the cycle after imem_rsp_valid.
REQ-022 PC increment SHALL be modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-023 S_WAIT, on imem_rsp_valid with squash=1: discard data, clear squash, go to S_REQ.
REQ-024 S_HOLD: inst_valid=1; inst, inst_pc held stable until inst_ack.
REQ-025 S_HOLD, on inst_ack: go to S_REQ; the next request is issued the following cycle; fetch_count increments by 1, wrapping at 2^32.
REQ-026 inst_valid SHALL be 0 in S_REQ and S_WAIT.
REQ-027 Redirect has highest priority in every state; pc<=redirect_pc at that posedge.
REQ-028 Redirect in S_REQ: stay in S_REQ; the request for the new PC is issued next cycle.
REQ-029 Redirect in S_WAIT with imem_rsp_valid=0: set squash=1, stay in S_WAIT.
REQ-030 Redirect in S_WAIT with imem_rsp_valid=1: drop the response, squash=0, go to S_REQ.
REQ-031 Redirect in S_HOLD: drop the held instruction, inst_valid=0 next cycle, go to S_REQ; a simultaneous inst_ack SHALL NOT increment fetch_count.
REQ-032 A second redirect while squash=1 SHALL update pc only; squash stays 1.
REQ-033 imem_rsp_valid outside S_WAIT is a protocol violation and SHALL be ignored without state change.
REQ-034 At most one request SHALL be outstanding at any time.

Reset
REQ-035 On reset==0: state=S_REQ, pc=RESET_PC, squash=0, inst=0, inst_pc=0, fetch_count=0, inst_valid=0.
REQ-036 imem_req_valid SHALL be 0 during the reset cycle and first asserts in the cycle after reset is released.
REQ-037 Reset during S_WAIT SHALL abandon the outstanding request; its later response arrives in S_REQ and is ignored per REQ-033.

Verification
REQ-038 Reset, then ready=1, rsp one cycle after accept, rdata=32'h1234_5678, ack on first inst_valid -> addr 0 then 4; inst=32'h1234_5678, inst_pc=0; fetch_count=1.
REQ-039 Ready held 0 for 5 cycles -> imem_req_valid=1 and imem_addr=0 constant throughout; no inst_valid.
REQ-040 Redirect to 32'h100 while in S_WAIT, rsp arrives 3 cycles later -> data dropped, next request addr=32'h100, fetch_count unchanged.
REQ-041 Redirect to 32'h200 in the same cycle as inst_ack in S_HOLD -> inst_valid=0 next cycle, fetch_count unchanged, next addr=32'h200.
REQ-042 Redirect to 32'hFFFF_FFFC, deliver one instruction -> inst_pc=32'hFFFF_FFFC, next addr=0.
REQ-043 Reset asserted in S_WAIT, stray rsp after release -> ignored; first request addr=RESET_PC; inst_valid stays 0 until its response.
